// File: rtl/cpu_pkg.sv
// Shared types and defaults for the MDR / memory handshake block.
package cpu_pkg;

    localparam int DATA_W      = 32;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/reg32.sv
// 32-bit register with synchronous active-low clear and load enable.
module reg32
    import cpu_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_clear_n,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Clear has priority over load; otherwise hold.
    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mdr_mem_if.sv
// Memory Data Register plus the req/ack memory transaction engine behind it.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no transaction; accepts rd_req > wr_req > MDRin
// ST_RD_WAIT | read issued, waiting for mem_ack (MDR <= mem_rdata)
// ST_WR_WAIT | write issued, waiting for mem_ack (MDR unchanged)
module mdr_mem_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MDRin,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [DATA_W-1:0] busMuxIn_MDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Counter is 8 bits wide, which covers the whole supported TIMEOUT range.
    localparam logic [7:0] TC = 8'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_we, w_we_nxt;
    logic              r_req, w_req_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              w_mdr_ld;
    logic [DATA_W-1:0] w_mdr_d;
    logic [DATA_W-1:0] w_mdr_q;

    // Next-state and registered-output decode; everything holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = r_we;
        w_req_nxt   = r_req;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_mdr_ld    = 1'b0;
        w_mdr_d     = bus_in;

        case (r_state)
            ST_IDLE: begin
                if (rd_req) begin
                    w_addr_nxt  = mar_addr;
                    w_we_nxt    = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RD_WAIT;
                end else if (wr_req) begin
                    w_addr_nxt  = mar_addr;
                    w_wdata_nxt = w_mdr_q;
                    w_we_nxt    = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WR_WAIT;
                end else if (MDRin) begin
                    w_mdr_ld = 1'b1;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                // An ack on the timeout edge still completes normally.
                if (mem_ack) begin
                    w_mdr_ld    = (r_state == ST_RD_WAIT);
                    w_mdr_d     = mem_rdata;
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == TC) begin
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_req   <= w_req_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    reg32 u_mdr (
        .i_clock   (clock),
        .i_clear_n (clear_n),
        .i_ld      (w_mdr_ld),
        .i_d       (w_mdr_d),
        .o_q       (w_mdr_q)
    );

    assign busMuxIn_MDR = w_mdr_q;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_we       = r_we;
    assign mem_req      = r_req;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Scoreboard bench for mdr_mem_if: stimulus pushes expected transaction
// outcomes, a negedge monitor pops and compares on each completion.
module tb_mdr_mem_if;

    localparam int AW = 9;
    localparam int TO = 16;

    logic          clock;
    logic          clear_n;
    logic [31:0]   bus_in;
    logic          MDRin;
    logic [AW-1:0] mar_addr;
    logic          rd_req;
    logic          wr_req;
    logic [31:0]   busMuxIn_MDR;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_req;
    logic          mem_we;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic          err;

    mdr_mem_if #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .bus_in       (bus_in),
        .MDRin        (MDRin),
        .mar_addr     (mar_addr),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .busMuxIn_MDR (busMuxIn_MDR),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Physical memory answered by the bench; reference memory kept by the model.
    logic [31:0] phys_mem [512];
    logic [31:0] ref_mem  [512];
    logic [31:0] m_mdr;

    always_comb mem_rdata = phys_mem[mem_addr];

    typedef struct {
        bit          is_wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          cycles;
        bit          done;
        bit          err;
        logic [31:0] mdr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: tracks each mem_req window and checks it when busy falls.
    bit          prev_busy = 0;
    int          req_cyc   = 0;
    bit          stable    = 1;
    bit          chk_done_next = 0;
    logic [8:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;

    always @(negedge clock) begin
        exp_t e;
        if (!clear_n) begin
            prev_busy     = 0;
            req_cyc       = 0;
            stable        = 1;
            chk_done_next = 0;
        end else begin
            if (chk_done_next) begin
                check("done_one_cycle", done, 1'b0);
                chk_done_next = 0;
            end
            if (mem_req) begin
                if (req_cyc == 0) begin
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    stable = 0;
                end
                req_cyc++;
            end
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_completion: scoreboard empty at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("req_cycles", req_cyc, e.cycles);
                    check("mem_addr", cap_addr, e.addr);
                    check("mem_we", cap_we, e.is_wr);
                    if (e.is_wr) check("mem_wdata", cap_wdata, e.wdata);
                    check("held_stable", stable, 1'b1);
                    check("done", done, e.done);
                    check("err", err, e.err);
                    check("mdr", busMuxIn_MDR, e.mdr);
                    chk_done_next = e.done;
                end
                req_cyc = 0;
                stable  = 1;
            end
            prev_busy = busy;
        end
    end

    // Request with ack after k cycles (k=0: never acked, expect timeout).
    // jam drives every other request input while busy; contend adds
    // wr_req and MDRin on the accepting edge.
    task automatic do_req(input bit wr, input logic [8:0] a, input int k,
                          input bit jam, input bit contend);
        exp_t e;
        int   n;
        e.is_wr  = wr;
        e.addr   = a;
        e.wdata  = m_mdr;
        e.cycles = (k != 0) ? k : TO;
        e.done   = (k != 0);
        e.err    = (k == 0);
        if (k != 0 && !wr) m_mdr = ref_mem[a];
        if (k != 0 && wr) ref_mem[a] = m_mdr;
        e.mdr = m_mdr;
        sb.push_back(e);

        mar_addr = a;
        if (wr) wr_req = 1'b1; else rd_req = 1'b1;
        if (contend) begin
            wr_req = 1'b1;
            MDRin  = 1'b1;
            bus_in = $urandom;
        end
        @(posedge clock); #1;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        MDRin    = 1'b0;
        mar_addr = AW'($urandom);
        n = (k != 0) ? k : TO;
        for (int c = 1; c <= n; c++) begin
            if (jam && c < n) begin
                MDRin  = 1'b1;
                bus_in = 32'hFFFF_FFFF;
                rd_req = $urandom_range(0, 1);
                wr_req = $urandom_range(0, 1);
            end
            if (c == n) begin
                MDRin  = 1'b0;
                rd_req = 1'b0;
                wr_req = 1'b0;
                if (k != 0) begin
                    mem_ack = 1'b1;
                    if (wr) phys_mem[mem_addr] = mem_wdata;
                end
            end
            @(posedge clock); #1;
        end
        mem_ack = 1'b0;
    endtask

    // MDRin in idle; a stray mem_ack may accompany it and must be ignored.
    task automatic do_load(input logic [31:0] v, input bit stray_ack);
        MDRin   = 1'b1;
        bus_in  = v;
        mem_ack = stray_ack;
        @(posedge clock); #1;
        MDRin   = 1'b0;
        mem_ack = 1'b0;
        m_mdr   = v;
        check("load_mdr", busMuxIn_MDR, v);
        check("load_no_req", mem_req, 1'b0);
        check("load_no_done", done, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mdr"}, busMuxIn_MDR, 32'h0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_req"}, mem_req, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (sb.size() != 0 && b < budget) begin
            @(posedge clock); #1;
            b++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outstanding expected %0d", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int r;
        logic [8:0] a;
        clear_n  = 1'b0;
        bus_in   = '0;
        MDRin    = 1'b0;
        mar_addr = '0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        mem_ack  = 1'b0;
        m_mdr    = '0;
        for (int i = 0; i < 512; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[9'h05A] = 32'h1234_5678;
        ref_mem[9'h05A]  = 32'h1234_5678;
        phys_mem[9'h0F0] = 32'hA5A5_5A5A;
        ref_mem[9'h0F0]  = 32'hA5A5_5A5A;

        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        clear_n = 1'b1;

        do_load(32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 9'h05A, 3, 1'b0, 1'b0);
        do_load(32'hCAFE_F00D, 1'b1);
        do_req(1'b1, 9'h123, 1, 1'b0, 1'b0);
        do_req(1'b0, 9'h0AB, 0, 1'b0, 1'b0);
        @(posedge clock); #1;
        check("err_sticky", err, 1'b1);
        do_req(1'b1, 9'h0CD, 2, 1'b0, 1'b0);
        check("err_cleared", err, 1'b0);
        do_req(1'b0, 9'h123, 2, 1'b1, 1'b1);
        do_req(1'b1, 9'h044, TO, 1'b1, 1'b0);
        @(posedge clock); #1;
        drain(10);

        // Reset in the middle of a read, then a late ack.
        mar_addr = 9'h0F0;
        rd_req   = 1'b1;
        @(posedge clock); #1;
        rd_req = 1'b0;
        @(posedge clock); #1;
        clear_n = 1'b0;
        @(posedge clock); #1;
        check_all_zero("midreset");
        clear_n = 1'b1;
        mem_ack = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        check("late_ack_mdr", busMuxIn_MDR, 32'h0);
        check("late_ack_done", done, 1'b0);
        check("late_ack_busy", busy, 1'b0);
        m_mdr = '0;

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 11);
            a = 9'($urandom);
            if (r < 3)       do_load($urandom, $urandom_range(0, 1));
            else if (r < 6)  do_req(1'b0, a, $urandom_range(1, 5), $urandom_range(0, 1), 1'b0);
            else if (r < 9)  do_req(1'b1, a, $urandom_range(1, 5), $urandom_range(0, 1), 1'b0);
            else if (r == 9) do_req(1'b0, a, $urandom_range(1, 4), 1'b1, 1'b1);
            else             do_req(r[0], a, 0, $urandom_range(0, 1), 1'b0);
        end
        @(posedge clock); #1;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
